// File: rtl/dot_product_mac_pipe.sv
// ---------------------------------------------------------------------------
// dot_product_mac_pipe
//
// Pipelined multiply-accumulate unit. One operand pair is accepted per beat.
// Products are summed until the beat flagged in_last, then one result per
// vector is emitted together with a sticky overflow flag.
//
// Handshake: there is no ready signal. A beat is accepted on every rising
// edge where ce && in_valid. A result is presented while out_valid is high,
// and the consumer takes it on an edge where out_valid && ce. With ce low,
// every register holds, including out_valid.
//
// Parameters
//   DIN0_WIDTH  operand A width
//   DIN1_WIDTH  operand B width
//   ACC_WIDTH   accumulator/result width (>= DIN0_WIDTH+DIN1_WIDTH)
//   NUM_STAGE   multiplier register stages (1..4)
//   SIGNED      0: unsigned, zero-extended; 1: two's complement, sign-extended
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ce         clock enable; low freezes every register
//   in_valid   beat strobe (qualified by ce)
//   in_last    beat is the final element of its vector
//   din0/din1  operands A and B
//   out_valid  dout/overflow hold a new result
//   dout       dot product modulo 2^ACC_WIDTH
//   overflow   accumulation left the ACC_WIDTH range at least once
// ---------------------------------------------------------------------------
module dot_product_mac_pipe #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 39,
  parameter int ACC_WIDTH  = 80,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  overflow
);

  localparam int PW        = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit IS_SIGNED = (SIGNED != 0);

  // -------------------------------------------------------------------------
  // Operand extension and product. Both operands are widened to the full
  // product width first, so a plain PW-bit multiply yields the exact product
  // in either signedness (the low PW bits of a two's complement product).
  // -------------------------------------------------------------------------
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod_d;

  always_comb begin
    a_ext  = {{DIN1_WIDTH{IS_SIGNED & din0[DIN0_WIDTH-1]}}, din0};
    b_ext  = {{DIN0_WIDTH{IS_SIGNED & din1[DIN1_WIDTH-1]}}, din1};
    prod_d = a_ext * b_ext;
  end

  // -------------------------------------------------------------------------
  // Multiplier pipeline with matching valid/last shift register.
  // -------------------------------------------------------------------------
  logic [PW-1:0]        prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q;
  logic [NUM_STAGE-1:0] lst_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
      vld_q <= '0;
      lst_q <= '0;
    end else if (ce) begin
      prod_q[0] <= prod_d;
      vld_q[0]  <= in_valid;
      lst_q[0]  <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        lst_q[i]  <= lst_q[i-1];
      end
    end
  end

  // Product at the end of the pipe, extended to the accumulator width.
  logic [PW-1:0]        p_st;
  logic [ACC_WIDTH-1:0] p_acc;

  assign p_st = prod_q[NUM_STAGE-1];

  generate
    if (ACC_WIDTH > PW) begin : g_ext
      assign p_acc = {{(ACC_WIDTH-PW){IS_SIGNED & p_st[PW-1]}}, p_st};
    end else begin : g_noext
      assign p_acc = p_st;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Accumulator stage.
  // -------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 first_q, first_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 ovfl_q, ovfl_d;
  logic                 out_valid_q, out_valid_d;

  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 add_ovf;
  logic                 ovf_upd;
  logic                 beat_v;
  logic                 beat_l;

  always_comb begin
    beat_v = vld_q[NUM_STAGE-1];
    beat_l = lst_q[NUM_STAGE-1];

    // The first beat of a vector starts from zero regardless of acc_q.
    base         = first_q ? '0 : acc_q;
    {carry, sum} = {1'b0, base} + {1'b0, p_acc};

    // Signed overflow: same-sign operands giving an opposite-sign sum.
    if (IS_SIGNED) begin
      add_ovf = (base[ACC_WIDTH-1] == p_acc[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1]  != base[ACC_WIDTH-1]);
    end else begin
      add_ovf = carry;
    end
    ovf_upd = add_ovf | (~first_q & ovf_q);

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    dout_d      = dout_q;
    ovfl_d      = ovfl_q;
    // out_valid is a one-beat pulse; only an arriving last beat re-raises it.
    out_valid_d = 1'b0;

    if (beat_v) begin
      if (beat_l) begin
        dout_d      = sum;
        ovfl_d      = ovf_upd;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d   = sum;
        ovf_d   = ovf_upd;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      dout_q      <= '0;
      ovfl_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      dout_q      <= dout_d;
      ovfl_q      <= ovfl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign overflow  = ovfl_q;

endmodule

// File: tb/tb_dot_product_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_dot_product_mac_pipe
//
// Four instances share clock, reset, ce and beat strobes:
//   u0: defaults (32/39/80, 2 stages, unsigned)
//   u1: 8/8/20, 1 stage, signed
//   u2: 4/4/9, 3 stages, unsigned (overflows easily)
//   u3: 4/4/8, 4 stages, signed (accumulator equals product width)
// Narrow instances see the low bits of the shared operand buses. Each
// instance has its own reference model (plain integer arithmetic on wide
// signed values) feeding an expected queue that the result monitor drains.
// ---------------------------------------------------------------------------
module tb_dot_product_mac_pipe;

  typedef logic signed [199:0] big_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        ce, in_valid, in_last;
  logic [31:0] din0;
  logic [38:0] din1;

  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;
  logic [79:0] dout0;
  logic [19:0] dout1;
  logic [8:0]  dout2;
  logic [7:0]  dout3;

  dot_product_mac_pipe u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0), .din1(din1), .out_valid(ov0), .dout(dout0), .overflow(of0));

  dot_product_mac_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .ACC_WIDTH(20),
                         .NUM_STAGE(1), .SIGNED(1)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0[7:0]), .din1(din1[7:0]), .out_valid(ov1), .dout(dout1), .overflow(of1));

  dot_product_mac_pipe #(.DIN0_WIDTH(4), .DIN1_WIDTH(4), .ACC_WIDTH(9),
                         .NUM_STAGE(3), .SIGNED(0)) u2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0[3:0]), .din1(din1[3:0]), .out_valid(ov2), .dout(dout2), .overflow(of2));

  dot_product_mac_pipe #(.DIN0_WIDTH(4), .DIN1_WIDTH(4), .ACC_WIDTH(8),
                         .NUM_STAGE(4), .SIGNED(1)) u3 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0[3:0]), .din1(din1[3:0]), .out_valid(ov3), .dout(dout3), .overflow(of3));

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [80:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];  // {ovf, dout}
  int          cyc_log0[$];
  logic [79:0] last_d[4];
  logic        last_o[4];
  int          cnt[4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  big_t m_acc[4];
  bit   m_ovf[4];
  bit   m_first[4];

  function automatic void get_cfg(input int id, output int w0, output int w1,
                                  output int wa, output bit sg);
    case (id)
      0:       begin w0 = 32; w1 = 39; wa = 80; sg = 1'b0; end
      1:       begin w0 = 8;  w1 = 8;  wa = 20; sg = 1'b1; end
      2:       begin w0 = 4;  w1 = 4;  wa = 9;  sg = 1'b0; end
      default: begin w0 = 4;  w1 = 4;  wa = 8;  sg = 1'b1; end
    endcase
  endfunction

  function automatic big_t pow2(input int w);
    big_t one = 1;
    return one <<< w;
  endfunction

  // Operand value as a mathematical integer.
  function automatic big_t ext(input logic [79:0] v, input int w, input bit sg);
    big_t r = 0;
    r[79:0] = v;
    r = r & (pow2(w) - 1);
    if (sg && r >= pow2(w - 1)) r = r - pow2(w);
    return r;
  endfunction

  function automatic bit in_range(input big_t v, input int w, input bit sg);
    if (sg) return (v >= -pow2(w - 1)) && (v < pow2(w - 1));
    return (v >= 0) && (v < pow2(w));
  endfunction

  function automatic big_t wrap(input big_t v, input int w, input bit sg);
    big_t r = v & (pow2(w) - 1);
    if (sg && r >= pow2(w - 1)) r = r - pow2(w);
    return r;
  endfunction

  task automatic push_exp(input int id, input logic [80:0] e);
    case (id)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      2: exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endtask

  task automatic model_beat(input int id, input logic [31:0] a, input logic [38:0] b,
                            input bit last);
    int w0, w1, wa;
    bit sg, on;
    big_t p, s, su;
    get_cfg(id, w0, w1, wa, sg);
    p  = ext({48'b0, a}, w0, sg) * ext({41'b0, b}, w1, sg);
    s  = (m_first[id] ? 0 : m_acc[id]) + p;
    on = !in_range(s, wa, sg) || (!m_first[id] && m_ovf[id]);
    s  = wrap(s, wa, sg);
    if (last) begin
      su = s & (pow2(wa) - 1);
      push_exp(id, {on, su[79:0]});
      m_acc[id]   = 0;
      m_ovf[id]   = 1'b0;
      m_first[id] = 1'b1;
    end else begin
      m_acc[id]   = s;
      m_ovf[id]   = on;
      m_first[id] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_ovf[i] = 1'b0; m_first[i] = 1'b1;
    end
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic sb_take(input int id, input logic [79:0] d, input logic o);
    int sz;
    logic [80:0] e;
    case (id)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      2: sz = exp_q2.size();
      default: sz = exp_q3.size();
    endcase
    tests_run++;
    assert (sz > 0)
    else begin
      tests_failed++;
      $error("FAIL sb_extra_u%0d observed=result 0x%0h expected=no result", id, d);
    end
    if (sz > 0) begin
      case (id)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        2: e = exp_q2.pop_front();
        default: e = exp_q3.pop_front();
      endcase
      check($sformatf("sb_dout_u%0d", id), d, e[79:0]);
      check($sformatf("sb_ovf_u%0d", id), o, e[80]);
    end
    last_d[id] = d;
    last_o[id] = o;
    cnt[id]++;
    if (id == 0) cyc_log0.push_back(cyc);
  endtask

  // The consumer takes a result on the next edge when out_valid && ce.
  always @(negedge clk) begin
    if (reset_n && ce) begin
      if (ov0) sb_take(0, dout0, of0);
      if (ov1) sb_take(1, {60'b0, dout1}, of1);
      if (ov2) sb_take(2, {71'b0, dout2}, of2);
      if (ov3) sb_take(3, {72'b0, dout3}, of3);
    end
  end

  // ---------------- driver tasks ----------------
  // e returns the value cyc takes on the edge that accepts the beat.
  task automatic beat(input logic [31:0] a, input logic [38:0] b, input bit last,
                      output int e);
    @(posedge clk); #1;
    ce = 1'b1; in_valid = 1'b1; in_last = last; din0 = a; din1 = b;
    e = cyc + 1;
    for (int i = 0; i < 4; i++) model_beat(i, a, b, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ce = 1'b1; in_valid = 1'b0; in_last = 1'($urandom);
      din0 = $urandom; din1 = {7'($urandom), $urandom};
    end
  endtask

  // ce low: even a valid-looking beat must be ignored.
  task automatic stall();
    @(posedge clk); #1;
    ce = 1'b0; in_valid = 1'b1; in_last = 1'($urandom);
    din0 = $urandom; din1 = {7'($urandom), $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ov0"}, ov0, 1'b0);
    check({tag, "_dout0"}, dout0, 80'd0);
    check({tag, "_of0"}, of0, 1'b0);
    check({tag, "_ov1"}, ov1, 1'b0);
    check({tag, "_dout1"}, dout1, 20'd0);
    check({tag, "_of1"}, of1, 1'b0);
    check({tag, "_ov2"}, ov2, 1'b0);
    check({tag, "_dout2"}, dout2, 9'd0);
    check({tag, "_ov3"}, ov3, 1'b0);
    check({tag, "_dout3"}, dout3, 8'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e, e1, len;
    for (int i = 0; i < 4; i++) begin last_d[i] = '0; last_o[i] = 1'b0; cnt[i] = 0; end
    model_reset();
    reset_n = 1'b0; ce = 1'b0; in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    // Unsigned three-beat vector on the defaults instance.
    cyc_log0.delete();
    beat(32'd3, 39'd4, 1'b0, e);
    beat(32'd5, 39'd6, 1'b0, e);
    beat(32'd7, 39'd8, 1'b1, e);
    idle(8);
    check("vec3_count", cyc_log0.size(), 1);
    if (cyc_log0.size() > 0) check("vec3_latency", cyc_log0[0], e + 2);
    check("vec3_dout", last_d[0], 80'd98);
    check("vec3_ovf", last_o[0], 1'b0);

    // Back-to-back single-element vectors, then idle and a two-beat vector.
    cyc_log0.delete();
    beat(32'd2, 39'd2, 1'b1, e1);
    beat(32'd1, 39'd9, 1'b1, e);
    idle(1);
    beat(32'd10, 39'd10, 1'b0, e);
    beat(32'd1, 39'd1, 1'b1, e);
    idle(8);
    check("b2b_count", cyc_log0.size(), 3);
    if (cyc_log0.size() == 3) begin
      check("b2b_latency", cyc_log0[0], e1 + 2);
      check("b2b_consecutive", cyc_log0[1], cyc_log0[0] + 1);
    end
    check("b2b_last_dout", last_d[0], 80'd101);

    // Signed vector on the 8/8/20 instance: (-3*5) + (7*-2) = -29.
    beat(32'hFFFF_FFFD, 39'd5, 1'b0, e);
    beat(32'd7, 39'h7F_FFFF_FFFE, 1'b1, e);
    idle(8);
    check("signed_dout", last_d[1], 80'hF_FFE3);
    check("signed_ovf", last_o[1], 1'b0);

    // Overflow on the 4/4/9 instance: 3*225 = 675 -> 163.
    beat(32'd15, 39'd15, 1'b0, e);
    beat(32'd15, 39'd15, 1'b0, e);
    beat(32'd15, 39'd15, 1'b1, e);
    idle(8);
    check("ovf_dout", last_d[2], 80'd163);
    check("ovf_flag", last_o[2], 1'b1);
    beat(32'd1, 39'd1, 1'b1, e);
    idle(8);
    check("ovf_clear_dout", last_d[2], 80'd1);
    check("ovf_clear_flag", last_o[2], 1'b0);

    // ce stall for two cycles right after the last beat.
    cyc_log0.delete();
    beat(32'd3, 39'd4, 1'b0, e);
    beat(32'd5, 39'd6, 1'b0, e);
    beat(32'd7, 39'd8, 1'b1, e);
    stall();
    stall();
    idle(8);
    check("stall_count", cyc_log0.size(), 1);
    if (cyc_log0.size() > 0) check("stall_latency", cyc_log0[0], e + 4);
    check("stall_dout", last_d[0], 80'd98);

    // Reset in the middle of a vector.
    cyc_log0.delete();
    beat(32'd4, 39'd4, 1'b0, e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    reset_n = 1'b1;
    beat(32'd1, 39'd1, 1'b1, e);
    idle(8);
    check("rst_count", cyc_log0.size(), 1);
    check("rst_dout", last_d[0], 80'd1);
    check("rst_ovf", last_o[0], 1'b0);

    // Random vectors with bubbles and ce stalls.
    for (int v = 0; v < 60; v++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 6) == 0) stall();
        beat($urandom, {7'($urandom), $urandom}, (k == len - 1), e);
      end
      if ($urandom_range(0, 3) == 0) stall();
    end
    idle(12);

    check("drain_u0", exp_q0.size(), 0);
    check("drain_u1", exp_q1.size(), 0);
    check("drain_u2", exp_q2.size(), 0);
    check("drain_u3", exp_q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dot_product_mac_pipe.md
# dot_product_mac_pipe

Parametrised, pipelined multiply-accumulate unit for the dot-product datapath, the successor to the fixed-width single-register multiplier cores. It consumes a stream of operand pairs, one pair per accepted beat. A vector's end is marked by `in_last`. It emits one dot-product result per vector and flags accumulator overflow. Configurable options:
- operand and accumulator widths,
- multiplier pipeline depth,
- signed or unsigned arithmetic.

## Interface
Parameters:
- `DIN0_WIDTH`, default 32: width of operand A.
- `DIN1_WIDTH`, default 39: width of operand B.
- `ACC_WIDTH`, default 80: accumulator and result width. Must be ≥ `DIN0_WIDTH+DIN1_WIDTH`.
- `NUM_STAGE`, default 2: multiplier register stages. Legal range is 1..4.
- `SIGNED`, default 0: 0 treats operands as unsigned and zero-extends them; 1 treats them as two's complement and sign-extends them.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous reset, active-low.
- `ce`, in, 1: clock enable. Low freezes every register in the block.
- `in_valid`, in, 1: a beat is accepted on a rising edge where `ce && in_valid`.
- `in_last`, in, 1: the accepted beat is the final element of the current vector.
- `din0`, in, `DIN0_WIDTH`: operand A.
- `din1`, in, `DIN1_WIDTH`: operand B.
- `out_valid`, out, 1: `dout` and `overflow` hold a new result.
- `dout`, out, `ACC_WIDTH`: dot product, modulo 2^`ACC_WIDTH`.
- `overflow`, out, 1: the accumulation for this result exceeded the `ACC_WIDTH` range at least once.

## Operation
- **Product:** `p = ext(din0) * ext(din1)`, exactly `DIN0_WIDTH+DIN1_WIDTH` bits, then extended to `ACC_WIDTH` according to `SIGNED`.
- **Multiplier pipeline:** the product passes through `NUM_STAGE` registers. A valid/last shift register of the same depth travels alongside it.
- **Accumulator stage:**
  - Holds `acc`, a sticky `ovf` bit and a `first` flag (reset value 1).
  - On a valid beat at the stage output: `sum = (first ? 0 : acc) + p`; `ovf` updates with the overflow of this addition, OR-ed with the previous `ovf` unless `first`.
  - Overflow definition: unsigned carry-out when `SIGNED=0`; signed overflow when `SIGNED=1`, i.e. operands of the same sign producing a result of the opposite sign.
  - Non-last beat: `acc <= sum`, `first <= 0`.
  - Last beat: `dout <= sum`, `overflow <= the updated ovf`, `out_valid <= 1`, `first <= 1`, `acc <= 0`.
- **Result output:** `out_valid` is asserted for exactly one `ce`-high cycle per vector. It is cleared on the next `ce`-high edge unless another last beat arrives at that edge. `dout` and `overflow` hold their values until the next result.
- **Single-element vector** (first beat has `in_last`=1): result = `p`.
- **Back-to-back vectors:** the beat after a last beat starts a new sum with no bubble. Consecutive last beats produce `out_valid` on consecutive cycles.
- **Idle beats:** cycles with `in_valid`=0 insert bubbles and do not change `acc`. `din0`, `din1` and `in_last` are ignored in such cycles.
- **`ce` low:** all state holds, including `out_valid`. The consumer samples a result only when `out_valid && ce`.
- **Reset:** `reset_n` low clears all pipeline valid bits, `acc`, `ovf`, `dout`, `out_valid` and `overflow` to 0, and sets `first` to 1. A partially accumulated vector is discarded; no result is produced for it.

## Timing
- With `ce` held high, a last beat accepted in cycle c gives `out_valid`=1 in cycle c+`NUM_STAGE`+1. With the defaults this is c+3.
- Each low-`ce` cycle in that window adds exactly one cycle of latency.
- Throughput is one beat per `ce`-high cycle. The block has no backpressure output.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `reset_n` asserts asynchronously and is deasserted synchronously to `clk` by the system. The first beat may be accepted on the first edge after deassertion.

## Test plan
- **Unsigned three-beat vector:**
  - Stimulus: defaults; pairs (3,4), (5,6), (7,8)-last, `ce`=1.
  - Expected: `out_valid` high in cycle c+3 only, `dout`=98, `overflow`=0.
- **Back-to-back vectors, single element, plus idle:**
  - Stimulus: (2,2)-last, then (1,9)-last on the next cycle; then one idle cycle, then (10,10),(1,1)-last.
  - Expected: results 4, 9, 101; the first two on consecutive cycles.
- **Signed vector:**
  - Stimulus: `SIGNED`=1, widths 8/8/20; pairs (-3,5), (7,-2)-last.
  - Expected: `dout`=0xFFFE3 (−29), `overflow`=0.
- **Overflow:**
  - Stimulus: `SIGNED`=0, widths 4/4/9; three beats of (15,15), last on the third.
  - Expected: `dout`=163 (675 mod 512), `overflow`=1.
  - Follow-up: the next vector (1,1)-last gives `overflow`=0.
- **`ce` stall:**
  - Stimulus: the defaults vector from the first scenario, with `ce` dropped for 2 cycles immediately after the last beat.
  - Expected: `out_valid` appears in cycle c+5; `dout`=98; no duplicate result is sampled with `ce` high.
- **Reset mid-vector:**
  - Stimulus: accept (4,4), pulse `reset_n` low, then send (1,1)-last.
  - Expected: no result for the aborted vector; `dout`=1 afterwards; all outputs read 0 while `reset_n` is low.
